// File: rtl/ddr_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ddr_port_arbiter
//  Purpose  : Round-robin arbiter sharing one LPDDR controller command port
//             among up to four requesters. It serialises commands, tracks
//             burst completion through the controller BUSY flag and aborts
//             grants whose bursts hang.
//  Revision : 1.0  initial release
// ============================================================================
module ddr_port_arbiter #(
   parameter int NUM_PORTS    = 3,
   parameter int BUSY_TIMEOUT = 64
) (
   input  logic                     SYS_CLK_100M,
   input  logic                     RESET_N,
   input  logic [NUM_PORTS-1:0]     REQ,
   input  logic [NUM_PORTS-1:0]     REQ_WR,
   input  logic [2*NUM_PORTS-1:0]   REQ_BA,
   input  logic [13*NUM_PORTS-1:0]  REQ_ROW,
   input  logic [10*NUM_PORTS-1:0]  REQ_COL,
   input  logic [4*NUM_PORTS-1:0]   REQ_LEN,
   output logic [NUM_PORTS-1:0]     ACK,
   output logic [NUM_PORTS-1:0]     DONE,
   output logic                     ERR,
   output logic [1:0]               GRANT_ID,
   output logic                     GRANT_VALID,
   output logic [1:0]               DDR_BA,
   output logic [12:0]              DDR_ROW,
   output logic [9:0]               DDR_COL,
   output logic [3:0]               DDR_WRITE_LENGTH,
   output logic                     DDR_WRITE,
   output logic                     DDR_READ,
   input  logic                     DDR_BUSY
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_ISSUE     = 2'd1,
      S_WAIT_DONE = 2'd2
   } state_t;

   localparam logic [7:0] C_TMO_LAST = 8'(BUSY_TIMEOUT - 1);
   localparam logic [1:0] C_LAST_RST = 2'(NUM_PORTS - 1);

   state_t                 r_state, w_state_nxt;
   logic [7:0]             r_timer, w_timer_nxt;
   logic [1:0]             r_last,  w_last_nxt;
   logic [1:0]             r_gid,   w_gid_nxt;
   logic                   r_gv,    w_gv_nxt;
   logic                   r_wr,    w_wr_nxt;
   logic                   r_rd,    w_rd_nxt;
   logic                   r_err,   w_err_nxt;
   logic [NUM_PORTS-1:0]   r_ack,   w_ack_nxt;
   logic [NUM_PORTS-1:0]   r_done,  w_done_nxt;
   logic [1:0]             r_ba,    w_ba_nxt;
   logic [12:0]            r_row,   w_row_nxt;
   logic [9:0]             r_col,   w_col_nxt;
   logic [3:0]             r_len,   w_len_nxt;

   logic                   w_win_found;
   logic [1:0]             w_win_idx;
   logic                   w_win_wr;
   logic [1:0]             w_win_ba;
   logic [12:0]            w_win_row;
   logic [9:0]             w_win_col;
   logic [3:0]             w_win_len;
   logic [NUM_PORTS-1:0]   w_gid_onehot;
   logic [7:0]             w_timer_inc;
   logic                   w_arb_hold;

   // Pick the requester closest after the last-served port (round-robin distance)
   always_comb begin
      int v_dist;
      int v_best;
      w_win_found = 1'b0;
      w_win_idx   = 2'd0;
      v_best      = NUM_PORTS;
      v_dist      = 0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         v_dist = p - int'(r_last) - 1;
         if (v_dist < 0) v_dist = v_dist + NUM_PORTS;
         if (REQ[p] && (v_dist < v_best)) begin
            v_best      = v_dist;
            w_win_idx   = 2'(p);
            w_win_found = 1'b1;
         end
      end
   end

   // Select the winner's command fields and decode the current grant to one-hot
   always_comb begin
      w_win_wr     = 1'b0;
      w_win_ba     = '0;
      w_win_row    = '0;
      w_win_col    = '0;
      w_win_len    = '0;
      w_gid_onehot = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (w_win_idx == 2'(p)) begin
            w_win_wr  = REQ_WR[p];
            w_win_ba  = REQ_BA[2*p +: 2];
            w_win_row = REQ_ROW[13*p +: 13];
            w_win_col = REQ_COL[10*p +: 10];
            w_win_len = REQ_LEN[4*p +: 4];
         end
         w_gid_onehot[p] = (r_gid == 2'(p));
      end
   end

   assign w_timer_inc = (r_timer == 8'hFF) ? r_timer : (r_timer + 8'd1);
   // While DONE/ERR is visible the finishing client has not yet had a chance
   // to drop its request, so arbitration waits one cycle.
   assign w_arb_hold  = (|r_done) | r_err;

   // Next-state and registered-output logic
   always_comb begin
      w_state_nxt = r_state;
      w_timer_nxt = r_timer;
      w_last_nxt  = r_last;
      w_gid_nxt   = r_gid;
      w_gv_nxt    = r_gv;
      w_wr_nxt    = r_wr;
      w_rd_nxt    = r_rd;
      w_err_nxt   = 1'b0;
      w_ack_nxt   = '0;
      w_done_nxt  = '0;
      w_ba_nxt    = r_ba;
      w_row_nxt   = r_row;
      w_col_nxt   = r_col;
      w_len_nxt   = r_len;
      case (r_state)
         S_IDLE: begin
            if (!DDR_BUSY && w_win_found && !w_arb_hold) begin
               w_ba_nxt    = w_win_ba;
               w_row_nxt   = w_win_row;
               w_col_nxt   = w_win_col;
               w_len_nxt   = w_win_len;
               w_wr_nxt    = w_win_wr;
               w_rd_nxt    = ~w_win_wr;
               w_gid_nxt   = w_win_idx;
               w_gv_nxt    = 1'b1;
               w_timer_nxt = 8'd0;
               w_state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (DDR_BUSY) begin
               w_ack_nxt   = w_gid_onehot;
               w_wr_nxt    = 1'b0;
               w_rd_nxt    = 1'b0;
               w_timer_nxt = 8'd0;
               w_state_nxt = S_WAIT_DONE;
            end else if (r_timer == C_TMO_LAST) begin
               w_err_nxt   = 1'b1;
               w_wr_nxt    = 1'b0;
               w_rd_nxt    = 1'b0;
               w_gv_nxt    = 1'b0;
               w_last_nxt  = r_gid;
               w_state_nxt = S_IDLE;
            end else begin
               w_timer_nxt = w_timer_inc;
            end
         end
         S_WAIT_DONE: begin
            if (!DDR_BUSY) begin
               w_done_nxt  = w_gid_onehot;
               w_gv_nxt    = 1'b0;
               w_last_nxt  = r_gid;
               w_state_nxt = S_IDLE;
            end else if (r_timer == C_TMO_LAST) begin
               w_err_nxt   = 1'b1;
               w_gv_nxt    = 1'b0;
               w_last_nxt  = r_gid;
               w_state_nxt = S_IDLE;
            end else begin
               w_timer_nxt = w_timer_inc;
            end
         end
         default: begin
            w_wr_nxt    = 1'b0;
            w_rd_nxt    = 1'b0;
            w_gv_nxt    = 1'b0;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State and output registers, cleared asynchronously
   always_ff @(posedge SYS_CLK_100M or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state <= S_IDLE;
         r_timer <= 8'd0;
         r_last  <= C_LAST_RST;
         r_gid   <= 2'd0;
         r_gv    <= 1'b0;
         r_wr    <= 1'b0;
         r_rd    <= 1'b0;
         r_err   <= 1'b0;
         r_ack   <= '0;
         r_done  <= '0;
         r_ba    <= '0;
         r_row   <= '0;
         r_col   <= '0;
         r_len   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_timer <= w_timer_nxt;
         r_last  <= w_last_nxt;
         r_gid   <= w_gid_nxt;
         r_gv    <= w_gv_nxt;
         r_wr    <= w_wr_nxt;
         r_rd    <= w_rd_nxt;
         r_err   <= w_err_nxt;
         r_ack   <= w_ack_nxt;
         r_done  <= w_done_nxt;
         r_ba    <= w_ba_nxt;
         r_row   <= w_row_nxt;
         r_col   <= w_col_nxt;
         r_len   <= w_len_nxt;
      end
   end

   assign ACK              = r_ack;
   assign DONE             = r_done;
   assign ERR              = r_err;
   assign GRANT_ID         = r_gid;
   assign GRANT_VALID      = r_gv;
   assign DDR_BA           = r_ba;
   assign DDR_ROW          = r_row;
   assign DDR_COL          = r_col;
   assign DDR_WRITE_LENGTH = r_len;
   assign DDR_WRITE        = r_wr;
   assign DDR_READ         = r_rd;

endmodule
`default_nettype wire

// File: tb/tb_ddr_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ddr_port_arbiter
//  Purpose  : Self-checking bench for ddr_port_arbiter with a transaction-
//             level round-robin reference model and a scripted controller.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ddr_port_arbiter;

   localparam int N = 3;
   localparam int T = 64;

   logic              clk   = 1'b0;
   logic              rst_n = 1'b0;
   logic [N-1:0]      req, req_wr;
   logic [2*N-1:0]    req_ba;
   logic [13*N-1:0]   req_row;
   logic [10*N-1:0]   req_col;
   logic [4*N-1:0]    req_len;
   logic              busy;

   logic [N-1:0]      ack, done;
   logic              err, gv, ddr_wr, ddr_rd;
   logic [1:0]        gid, ddr_ba;
   logic [12:0]       ddr_row;
   logic [9:0]        ddr_col;
   logic [3:0]        ddr_len;

   wire  [28:0]       w_fbus = {ddr_ba, ddr_row, ddr_col, ddr_len};
   wire  [3:0]        w_st   = {err, gv, ddr_wr, ddr_rd};

   int checks = 0;
   int errors = 0;
   int last_m;

   always #5 clk = ~clk;

   ddr_port_arbiter #(.NUM_PORTS(N), .BUSY_TIMEOUT(T)) u_dut (
      .SYS_CLK_100M     (clk),
      .RESET_N          (rst_n),
      .REQ              (req),
      .REQ_WR           (req_wr),
      .REQ_BA           (req_ba),
      .REQ_ROW          (req_row),
      .REQ_COL          (req_col),
      .REQ_LEN          (req_len),
      .ACK              (ack),
      .DONE             (done),
      .ERR              (err),
      .GRANT_ID         (gid),
      .GRANT_VALID      (gv),
      .DDR_BA           (ddr_ba),
      .DDR_ROW          (ddr_row),
      .DDR_COL          (ddr_col),
      .DDR_WRITE_LENGTH (ddr_len),
      .DDR_WRITE        (ddr_wr),
      .DDR_READ         (ddr_rd),
      .DDR_BUSY         (busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic rand_fields();
      for (int p = 0; p < N; p++) begin
         req_wr[p]          = 1'($urandom);
         req_ba[2*p +: 2]   = 2'($urandom);
         req_row[13*p +: 13] = 13'($urandom);
         req_col[10*p +: 10] = 10'($urandom);
         req_len[4*p +: 4]  = 4'($urandom);
      end
   endtask

   // Reference: first requesting port after the last one served, modulo N
   function automatic int model_pick(input logic [N-1:0] m);
      for (int k = 1; k <= N; k++)
         if (m[(last_m + k) % N]) return (last_m + k) % N;
      return 0;
   endfunction

   // mode 0: normal burst, 1: BUSY never rises, 2: BUSY stuck high after ACK
   task automatic do_txn(input int mode, input int init_k, input int d_in,
                         input int b_in, input bit keep);
      int            p, d, b;
      logic          wr_e;
      logic [28:0]   f_e;
      logic [N-1:0]  oh;
      if (req == '0) req[0] = 1'b1;
      if (init_k > 0) begin
         busy = 1'b1;
         repeat (init_k) begin
            step();
            check("init_block", {28'd0, w_st}, 32'd0);
         end
      end
      busy = 1'b0;
      p    = model_pick(req);
      wr_e = req_wr[p];
      f_e  = {req_ba[2*p +: 2], req_row[13*p +: 13], req_col[10*p +: 10], req_len[4*p +: 4]};
      oh   = '0;
      oh[p] = 1'b1;
      step();
      check("grant_id", {30'd0, gid}, p);
      check("grant_st", {28'd0, w_st}, {29'd0, 1'b1, wr_e, ~wr_e});
      check("grant_fields", {3'd0, w_fbus}, {3'd0, f_e});
      rand_fields();
      if (mode == 1) begin
         for (int n = 1; n < T; n++) begin
            step();
            check("issue_wait", {28'd0, w_st}, {29'd0, 1'b1, wr_e, ~wr_e});
            check("issue_fields", {3'd0, w_fbus}, {3'd0, f_e});
         end
         step();
         check("issue_tmo_st", {28'd0, w_st}, 32'h8);
         check("issue_tmo_ack", {29'd0, ack}, 32'd0);
         req[p] = 1'b0;
         last_m = p;
      end else begin
         d = (d_in < 0) ? int'($urandom_range(0, 10)) : d_in;
         repeat (d) begin
            step();
            check("issue_hold", {25'd0, ack, w_st}, {29'd0, 1'b1, wr_e, ~wr_e});
            check("hold_fields", {3'd0, w_fbus}, {3'd0, f_e});
         end
         busy = 1'b1;
         step();
         check("ack", {29'd0, ack}, {29'd0, oh});
         check("ack_st", {25'd0, done, w_st}, 32'h4);
         if (!keep) req[p] = 1'b0;
         if (mode == 2) begin
            for (int n = 1; n < T; n++) begin
               step();
               check("wait_hold", {22'd0, ack, done, w_st}, 32'h4);
            end
            step();
            check("wait_tmo_st", {28'd0, w_st}, 32'h8);
            check("wait_tmo_done", {29'd0, done}, 32'd0);
            req[p] = 1'b0;
            busy   = 1'b0;
            last_m = p;
         end else begin
            b = (b_in < 1) ? int'($urandom_range(1, 15)) : b_in;
            repeat (b - 1) begin
               step();
               check("burst", {22'd0, ack, done, w_st}, 32'h4);
            end
            busy = 1'b0;
            step();
            check("done", {29'd0, done}, {29'd0, oh});
            check("done_st", {25'd0, ack, w_st}, 32'd0);
            last_m = p;
         end
      end
      step();
      check("gap", {22'd0, ack, done, w_st}, 32'd0);
   endtask

   initial begin
      int mode;
      busy   = 1'b1;
      req    = '0;
      last_m = N - 1;
      rand_fields();
      #1;
      check("rst_ctl", {23'd0, ack, done, w_st, gid}, 32'd0);
      check("rst_fields", {3'd0, w_fbus}, 32'd0);
      repeat (2) step();
      rst_n = 1'b1;

      // controller busy after reset blocks the first read grant
      req = 3'b001;
      req_wr[0] = 1'b0;
      do_txn(0, 5, 2, 4, 1'b0);

      // all ports writing with requests held: strict rotation
      req = 3'b111;
      req_wr = 3'b111;
      repeat (4) do_txn(0, 0, 0, 10, 1'b1);

      // port 1 directed fields, stable until ACK despite later changes
      req = 3'b010;
      req_wr[1] = 1'b1;
      req_ba[3:2] = 2'd2;
      req_row[25:13] = 13'h0ABC;
      req_col[19:10] = 10'h155;
      req_len[7:4] = 4'd5;
      do_txn(0, 0, 3, 2, 1'b0);

      // hung issue, then the remaining port is served, then hung burst
      req = 3'b101;
      do_txn(1, 0, 0, 0, 1'b0);
      do_txn(0, 0, -1, -1, 1'b0);
      req = 3'b110;
      do_txn(2, 0, 1, 0, 1'b0);

      // randomized traffic
      for (int i = 0; i < 30; i++) begin
         req = (req & N'($urandom)) | N'($urandom);
         rand_fields();
         mode = int'($urandom_range(0, 9));
         mode = (mode < 8) ? 0 : (mode == 8) ? 1 : 2;
         do_txn(mode, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0,
                -1, -1, 1'($urandom));
      end

      // asynchronous reset in the middle of a burst
      req = '1;
      rand_fields();
      busy = 1'b0;
      step();
      check("pre_rst_gv", {31'd0, gv}, 32'd1);
      busy = 1'b1;
      step();
      step();
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_ctl", {23'd0, ack, done, w_st, gid}, 32'd0);
      check("mid_rst_fields", {3'd0, w_fbus}, 32'd0);
      step();
      rst_n  = 1'b1;
      busy   = 1'b0;
      req    = '1;
      last_m = N - 1;
      do_txn(0, 0, 1, 3, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
